// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that grants one finished execution-unit result per cycle onto the CDB.
// Latency 1: a transfer at edge N is broadcast on cdb_* during cycle N+1 (tag 0 is never broadcast).
// Backpressure: req_ready is the one-hot grant; rdy_in=0 freezes everything, flush suppresses grants.
// Optional macro CDB_STALL_CNT_EN adds a saturating stall_cnt output counting contended cycles.
module cdb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int TAG_WIDTH = 5,
  parameter int VAL_WIDTH = 32,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*VAL_WIDTH-1:0]  req_val,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [VAL_WIDTH-1:0]          cdb_val,
  output logic [SRC_W-1:0]              cdb_src
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic                 valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [VAL_WIDTH-1:0] val_q, val_d;
  logic [SRC_W-1:0]     src_q, src_d;

  logic [NUM_REQ-1:0]   grant;
  logic                 gnt_any;
  logic [SRC_W-1:0]     gnt_idx;
  logic [TAG_WIDTH-1:0] gnt_tag;
  logic [VAL_WIDTH-1:0] gnt_val;
  int                   idx;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!rst_in && rdy_in && !flush) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any    = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = SRC_W'(idx);
        end
      end
    end
  end

  // Select the granted unit's tag and value from the packed request buses.
  always_comb begin
    gnt_tag = '0;
    gnt_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        gnt_val = req_val[i*VAL_WIDTH +: VAL_WIDTH];
      end
    end
  end

  assign req_ready = grant;

  // Next broadcast state: one-cycle valid per non-zero-tag transfer, payload held otherwise.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    val_d   = val_q;
    src_d   = src_q;
    if (rdy_in) begin
      valid_d = 1'b0;
      if (gnt_any) begin
        ptr_d = gnt_idx;
        if (gnt_tag != '0) begin
          valid_d = 1'b1;
          tag_d   = gnt_tag;
          val_d   = gnt_val;
          src_d   = gnt_idx;
        end
      end
    end
  end

  // Broadcast registers and round-robin pointer; pointer resets so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      ptr_q   <= SRC_W'(NUM_REQ - 1);
      valid_q <= 1'b0;
      tag_q   <= '0;
      val_q   <= '0;
      src_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      val_q   <= val_d;
      src_q   <= src_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_val   = val_q;
  assign cdb_src   = src_q;

`ifdef CDB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Count enabled, non-flush cycles where more than one unit is waiting; saturate at all ones.
  always_comb begin
    stall_d = stall_q;
    if (rdy_in && !flush && ($countones(req_valid) > 1) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Contention counter register.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a request-level model predicts grants and broadcasts.
// Each enabled or reset edge pushes the expected CDB state; a monitor pops and compares after the edge.
// Edges with rdy_in=0 are checked against the unchanged model state (everything frozen).
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int TW = 5;
  localparam int VW = 32;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic [VW-1:0] val;
    logic [1:0]    src;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_in = 1'b1;
  logic            rdy_in = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*VW-1:0] req_val = '0;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [VW-1:0]   cdb_val;
  logic [1:0]      cdb_src;
`ifdef CDB_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  cdb_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW), .VAL_WIDTH(VW)) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_val   (req_val),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_val   (cdb_val),
    .cdb_src   (cdb_src)
`ifdef CDB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which units hold a result, what they hold, who went last.
  bit   [N-1:0]  pend = '0;
  logic [TW-1:0] utag [N];
  logic [VW-1:0] uval [N];
  int            last_winner = N - 1;
  exp_t          mst = '0;
  logic [31:0]   mstall = '0;
  exp_t          q[$];
  bit            mon_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // A unit that is idle picks up a new result with the given probability.
  task automatic refill(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom_range(99) < pct)) begin
        pend[i] = 1'b1;
        utag[i] = ($urandom_range(5) == 0) ? '0 : TW'($urandom_range(31, 1));
        uval[i] = $urandom;
      end
    end
  endtask

  task automatic load(input int i, input logic [TW-1:0] t, input logic [VW-1:0] v);
    pend[i] = 1'b1;
    utag[i] = t;
    uval[i] = v;
  endtask

  // One clock: drive inputs, check the grant, predict the CDB after the coming edge.
  task automatic step(input bit r, input bit rd, input bit fl);
    logic [N-1:0] exp_g;
    int           win;
    @(negedge clk);
    rst_in    = r;
    rdy_in    = rd;
    flush     = fl;
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW] = utag[i];
      req_val[i*VW +: VW] = uval[i];
    end
    #1;
    exp_g = '0;
    win   = -1;
    if (!r && rd && !fl) begin
      for (int k = 1; k <= N; k++) begin
        if (win < 0 && pend[(last_winner + k) % N]) win = (last_winner + k) % N;
      end
    end
    if (win >= 0) exp_g[win] = 1'b1;
    check("req_ready", req_ready, exp_g);
`ifdef CDB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, mstall);
`endif
    if (r) begin
      mst         = '0;
      last_winner = N - 1;
      pend        = '0;
      mstall      = '0;
    end else if (rd) begin
      if (!fl && ($countones(pend) > 1) && (mstall != 32'hFFFF_FFFF)) mstall = mstall + 1;
      mst.v = 1'b0;
      if (fl) begin
        pend = '0;
      end else if (win >= 0) begin
        last_winner = win;
        pend[win]   = 1'b0;
        if (utag[win] != 0) begin
          mst.v   = 1'b1;
          mst.tag = utag[win];
          mst.val = uval[win];
          mst.src = 2'(win);
        end
      end
    end
    if (r || rd) q.push_back(mst);
    mon_en = 1'b1;
  endtask

  // Monitor: after every edge compare the CDB against the scoreboard or the frozen model state.
  initial begin
    bit   act;
    exp_t e;
    forever begin
      @(posedge clk);
      act = rst_in || rdy_in;
      #1;
      if (mon_en) begin
        if (act) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
          end else begin
            e = q.pop_front();
            check("cdb_valid", cdb_valid, e.v);
            check("cdb_tag", cdb_tag, e.tag);
            check("cdb_val", cdb_val, e.val);
            check("cdb_src", cdb_src, e.src);
          end
        end else begin
          check("hold_valid", cdb_valid, mst.v);
          check("hold_tag", cdb_tag, mst.tag);
          check("hold_val", cdb_val, mst.val);
          check("hold_src", cdb_src, mst.src);
        end
      end
    end
  end

  initial begin
    bit r, rd, fl;
    for (int i = 0; i < N; i++) begin
      utag[i] = '0;
      uval[i] = '0;
    end
    // Reset, including a reset edge with rdy_in low, then an idle cycle showing reset state.
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    // Single request from unit 0, then the broadcast must drop.
    load(0, 5'd5, 32'h1234);
    step(0, 1, 0);
    step(0, 1, 0);
    // Fairness: all units always requesting.
    repeat (6) begin
      refill(100);
      for (int i = 0; i < N; i++) if (utag[i] == 0) utag[i] = 5'd9;
      step(0, 1, 0);
    end
    repeat (4) step(0, 1, 0);
    // Pointer skip: park the pointer on 0, then units 0 and 2 request.
    load(0, 5'd3, 32'hA0);
    step(0, 1, 0);
    load(0, 5'd4, 32'hB0);
    load(2, 5'd6, 32'hC2);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    // Flush with a pending request.
    load(1, 5'd7, 32'hD1);
    step(0, 1, 1);
    step(0, 1, 0);
    // rdy_in low for three cycles during a broadcast.
    load(0, 5'd11, 32'hE0);
    step(0, 1, 0);
    load(1, 5'd12, 32'hE1);
    repeat (3) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    // Tag zero: transfer completes but nothing is broadcast.
    load(0, 5'd0, 32'hF0);
    step(0, 1, 0);
    step(0, 1, 0);
    // Reset while a broadcast is pending and a request waits.
    load(2, 5'd13, 32'h77);
    step(0, 1, 0);
    load(1, 5'd14, 32'h88);
    step(1, 1, 0);
    step(0, 1, 0);
`ifdef CDB_STALL_CNT_EN
    // Two units contending for four cycles.
    step(1, 1, 0);
    repeat (4) begin
      if (!pend[0]) load(0, 5'd1, $urandom);
      if (!pend[1]) load(1, 5'd2, $urandom);
      step(0, 1, 0);
    end
    step(0, 0, 0);
`endif
    // Randomized traffic.
    repeat (3000) begin
      refill(40);
      r  = ($urandom_range(199) == 0);
      rd = ($urandom_range(99) < 80);
      fl = ($urandom_range(99) < 7);
      step(r, rd, fl);
    end
    step(0, 1, 0);
    step(0, 1, 0);
    @(posedge clk);
    #2;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
